// File: rtl/serdesphy_ana_pkg.sv
// Shared encodings for the SerDes PHY analog debug output stage.
// Mode select values and the debug DAC FSM state constants.
package serdesphy_ana_pkg;

    localparam logic [1:0] DBG_MODE_OFF    = 2'b00;
    localparam logic [1:0] DBG_MODE_DIRECT = 2'b01;
    localparam logic [1:0] DBG_MODE_PWM    = 2'b10;
    localparam logic [1:0] DBG_MODE_SDM    = 2'b11;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

endpackage

// File: rtl/serdesphy_ana_dbg_modulator.sv
// Bitstream generator for the analog debug pin: direct LSB, PWM
// and first-order sigma-delta, driven by the next-cycle sample.
module serdesphy_ana_dbg_modulator
    import serdesphy_ana_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic [1:0]        mode,
    input  logic              run,
    input  logic              clear,
    output logic [DATA_W-1:0] pwm_cnt,
    output logic              dbg_ana
);

    logic              active;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] pwm_nxt;
    logic [DATA_W:0]   acc_nxt;
    logic              bit_nxt;

    // Next counter values and the output bit they produce.
    // The first RUN cycle shows count 0, later cycles advance.
    always_comb begin
        pwm_nxt = '0;
        if (active) begin
            pwm_nxt = pwm_cnt + 1'b1;
        end
        acc_nxt = {1'b0, acc[DATA_W-1:0]} + {1'b0, sample};
        bit_nxt = 1'b0;
        case (mode)
            DBG_MODE_DIRECT: bit_nxt = sample[0];
            DBG_MODE_PWM:    bit_nxt = (pwm_nxt < sample);
            DBG_MODE_SDM:    bit_nxt = acc_nxt[DATA_W];
            default:         bit_nxt = 1'b0;
        endcase
    end

    // Counters and output flop; held at zero outside RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            pwm_cnt <= '0;
            acc     <= '0;
            dbg_ana <= 1'b0;
        end else if (clear || !run) begin
            active  <= 1'b0;
            pwm_cnt <= '0;
            acc     <= '0;
            dbg_ana <= 1'b0;
        end else begin
            active  <= 1'b1;
            pwm_cnt <= (mode == DBG_MODE_PWM) ? pwm_nxt : '0;
            acc     <= (mode == DBG_MODE_SDM) ? acc_nxt : '0;
            dbg_ana <= bit_nxt;
        end
    end

endmodule

// File: rtl/serdesphy_ana_debug_dac.sv
// Multi-channel analog debug DAC: channel mux, sample capture,
// change-triggered settle blanking and the bitstream modulator.
module serdesphy_ana_debug_dac
    import serdesphy_ana_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     hold,
    input  logic [NUM_CH*DATA_W-1:0] debug_data,
    output logic                     dbg_ana,
    output logic                     settling,
    output logic [DATA_W-1:0]        sample
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [7:0]        settle_cnt;
    logic [7:0]        settle_cnt_d;
    logic [SEL_W-1:0]  ch_sel_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] sample_d;
    logic [DATA_W-1:0] mux_word;
    logic [DATA_W-1:0] pwm_cnt;
    logic              changed;
    logic              pwm_wrap;
    logic              run_d;

    // Channel mux; selects beyond the last channel read as zero.
    always_comb begin
        mux_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == SEL_W'(c)) begin
                mux_word = debug_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign changed  = (ch_sel != ch_sel_q) || (mode != mode_q);
    assign pwm_wrap = (pwm_cnt == {DATA_W{1'b1}});

    // FSM next state, settle counting and sample capture policy.
    always_comb begin
        state_d      = state;
        settle_cnt_d = settle_cnt;
        sample_d     = sample;
        if (!enable || mode == DBG_MODE_OFF) begin
            state_d      = ST_OFF;
            settle_cnt_d = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
                ST_SETTLE: begin
                    if (changed) begin
                        settle_cnt_d = '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state_d      = ST_RUN;
                        settle_cnt_d = '0;
                        sample_d     = mux_word;
                    end else begin
                        settle_cnt_d = settle_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (changed) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end else if (!hold) begin
                        if (mode != DBG_MODE_PWM || pwm_wrap) begin
                            sample_d = mux_word;
                        end
                    end
                end
                default: begin
                    state_d      = ST_OFF;
                    settle_cnt_d = '0;
                end
            endcase
        end
    end

    // State, settle counter, input history and captured sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            ch_sel_q   <= '0;
            mode_q     <= DBG_MODE_OFF;
            sample     <= '0;
        end else begin
            state      <= state_d;
            settle_cnt <= settle_cnt_d;
            ch_sel_q   <= ch_sel;
            mode_q     <= mode;
            sample     <= sample_d;
        end
    end

    assign settling = (state == ST_SETTLE);
    assign run_d    = (state_d == ST_RUN);

    serdesphy_ana_dbg_modulator #(
        .DATA_W (DATA_W)
    ) u_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample_d),
        .mode    (mode),
        .run     (run_d),
        .clear   (!run_d),
        .pwm_cnt (pwm_cnt),
        .dbg_ana (dbg_ana)
    );

endmodule

// File: tb/tb_serdesphy_ana_debug_dac.sv
// Self-checking bench for serdesphy_ana_debug_dac.
// Expected bitstreams are queued at stimulus time and popped per cycle.
module tb_serdesphy_ana_debug_dac;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int SW = 2;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic hold = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [SW-1:0] ch_sel = '0;
    logic [NC*DW-1:0] debug_data = '0;
    logic dbg_ana;
    logic settling;
    logic [DW-1:0] sample;

    logic [SW-1:0] ch_sel3 = 2'd3;
    logic [3*DW-1:0] debug_data3 = '1;
    logic dbg_ana3;
    logic settling3;
    logic [DW-1:0] sample3;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    serdesphy_ana_debug_dac #(
        .DATA_W(DW), .NUM_CH(NC), .SEL_W(SW), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .ch_sel(ch_sel), .hold(hold), .debug_data(debug_data),
        .dbg_ana(dbg_ana), .settling(settling), .sample(sample)
    );

    serdesphy_ana_debug_dac #(
        .DATA_W(DW), .NUM_CH(3), .SEL_W(2), .SETTLE_CYC(SC)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .ch_sel(ch_sel3), .hold(hold), .debug_data(debug_data3),
        .dbg_ana(dbg_ana3), .settling(settling3), .sample(sample3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [DW-1:0] v);
        debug_data[c*DW +: DW] = v;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (dbg_ana !== 1'b0 || settling !== 1'b0 || sample !== '0) begin
            errors++;
            $display("FAIL reset: dbg_ana=%b settling=%b sample=%h, need 0/0/00",
                     dbg_ana, settling, sample);
        end
        tick();
        checks++;
        if (dbg_ana !== 1'b0 || settling !== 1'b0) begin
            errors++;
            $display("FAIL reset_clk: dbg_ana=%b settling=%b, need 0/0",
                     dbg_ana, settling);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (settling !== 1'b0 || dbg_ana !== 1'b0) begin
            errors++;
            $display("FAIL idle_off: settling=%b dbg_ana=%b, need 0/0",
                     settling, dbg_ana);
        end
    endtask

    task automatic test_sdm();
        int ones;
        logic e;
        ones = 0;
        set_ch(1, 8'h40);
        ch_sel = 2'd1;
        mode = 2'b11;
        enable = 1'b1;
        for (int i = 0; i < SC; i++) begin
            tick();
            checks++;
            if (settling !== 1'b1 || dbg_ana !== 1'b0) begin
                errors++;
                $display("FAIL sdm_settle %0d: settling=%b dbg_ana=%b, need 1/0",
                         i, settling, dbg_ana);
            end
        end
        for (int i = 0; i < 256; i++) exp_q.push_back((i % 4) == 3);
        for (int i = 0; i < 256; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (settling !== 1'b0 || dbg_ana !== e) begin
                errors++;
                $display("FAIL sdm_bit %0d: dbg_ana=%b settling=%b, need %b/0",
                         i, dbg_ana, settling, e);
            end
            if (dbg_ana === 1'b1) ones++;
        end
        checks++;
        if (ones != 64) begin
            errors++;
            $display("FAIL sdm_density: ones=%0d, need 64", ones);
        end
    endtask

    task automatic test_pwm();
        logic e;
        enable = 1'b0;
        tick();
        set_ch(0, 8'h80);
        ch_sel = 2'd0;
        mode = 2'b10;
        enable = 1'b1;
        for (int i = 0; i < SC; i++) begin
            tick();
            checks++;
            if (settling !== 1'b1 || dbg_ana !== 1'b0) begin
                errors++;
                $display("FAIL pwm_settle %0d: settling=%b dbg_ana=%b, need 1/0",
                         i, settling, dbg_ana);
            end
        end
        for (int i = 0; i < 256; i++) exp_q.push_back(i < 128);
        for (int i = 0; i < 256; i++) exp_q.push_back(i < 32);
        for (int i = 0; i < 512; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (dbg_ana !== e) begin
                errors++;
                $display("FAIL pwm_bit %0d: dbg_ana=%b, need %b", i, dbg_ana, e);
            end
            if (i == 100) set_ch(0, 8'h20);
            if (i == 200) begin
                checks++;
                if (sample !== 8'h80) begin
                    errors++;
                    $display("FAIL pwm_no_trunc: sample=%h, need 80", sample);
                end
            end
            if (i == 300) begin
                checks++;
                if (sample !== 8'h20) begin
                    errors++;
                    $display("FAIL pwm_reload: sample=%h, need 20", sample);
                end
            end
        end
    endtask

    task automatic test_sel_hold();
        set_ch(2, 8'h5A);
        hold = 1'b1;
        ch_sel = 2'd2;
        for (int i = 0; i < SC; i++) begin
            tick();
            checks++;
            if (settling !== 1'b1 || dbg_ana !== 1'b0) begin
                errors++;
                $display("FAIL sel_settle %0d: settling=%b dbg_ana=%b, need 1/0",
                         i, settling, dbg_ana);
            end
        end
        tick();
        checks++;
        if (sample !== 8'h5A || settling !== 1'b0 || dbg_ana !== 1'b1) begin
            errors++;
            $display("FAIL sel_hold_load: sample=%h settling=%b dbg_ana=%b, need 5a/0/1",
                     sample, settling, dbg_ana);
        end
    endtask

    task automatic test_direct();
        logic v;
        logic e;
        hold = 1'b0;
        ch_sel = 2'd0;
        mode = 2'b01;
        set_ch(0, 8'h00);
        for (int i = 0; i < SC; i++) begin
            tick();
            checks++;
            if (settling !== 1'b1 || dbg_ana !== 1'b0) begin
                errors++;
                $display("FAIL dir_settle %0d: settling=%b dbg_ana=%b, need 1/0",
                         i, settling, dbg_ana);
            end
        end
        tick();
        for (int i = 0; i < 16; i++) begin
            v = (i % 2) == 1;
            hold = (i >= 8);
            set_ch(0, {7'd0, v});
            exp_q.push_back((i < 8) ? v : 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (dbg_ana !== e) begin
                errors++;
                $display("FAIL dir_bit %0d: dbg_ana=%b, need %b", i, dbg_ana, e);
            end
        end
        checks++;
        if (sample !== 8'h01) begin
            errors++;
            $display("FAIL dir_hold_sample: sample=%h, need 01", sample);
        end
        hold = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic e;
        logic [1:0] mlist [3];
        mlist[0] = 2'b01;
        mlist[1] = 2'b10;
        mlist[2] = 2'b11;
        enable = 1'b1;
        for (int m = 0; m < 3; m++) begin
            mode = mlist[m];
            for (int i = 0; i < 24; i++) exp_q.push_back(1'b0);
            for (int i = 0; i < 24; i++) begin
                tick();
                e = exp_q.pop_front();
                checks++;
                if (dbg_ana3 !== e) begin
                    errors++;
                    $display("FAIL oor_bit m%0d c%0d: dbg_ana=%b, need %b",
                             m, i, dbg_ana3, e);
                end
            end
            checks++;
            if (sample3 !== '0) begin
                errors++;
                $display("FAIL oor_sample m%0d: sample=%h, need 00", m, sample3);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_ch(0, 8'h80);
        ch_sel = 2'd0;
        mode = 2'b10;
        enable = 1'b1;
        repeat (SC + 1 + 9) tick();
        checks++;
        if (dbg_ana !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_high: dbg_ana=%b, need 1", dbg_ana);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dbg_ana !== 1'b0 || sample !== '0 || settling !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: dbg_ana=%b sample=%h settling=%b, need 0/00/0",
                     dbg_ana, sample, settling);
        end
        tick();
        #1 rst_n = 1'b1;
        for (int i = 0; i < SC; i++) begin
            tick();
            checks++;
            if (settling !== 1'b1 || dbg_ana !== 1'b0) begin
                errors++;
                $display("FAIL rst_settle %0d: settling=%b dbg_ana=%b, need 1/0",
                         i, settling, dbg_ana);
            end
        end
        tick();
        checks++;
        if (dbg_ana !== 1'b1 || sample !== 8'h80 || settling !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: dbg_ana=%b sample=%h settling=%b, need 1/80/0",
                     dbg_ana, sample, settling);
        end
    endtask

    initial begin
        test_reset();
        test_sdm();
        test_pwm();
        test_sel_hold();
        test_direct();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdesphy_ana_debug_dac.md
# serdesphy_ana_debug_dac

Parametrised multi-channel analog debug output stage for the SerDes PHY analog common block. It selects one of `NUM_CH` digital debug words and captures it with hold support. It then converts the word onto the single `dbg_ana` pin using one of four modes: off, direct LSB, PWM, or first-order sigma-delta. A settle window blanks the output whenever the source or mode changes, so an external RC filter never sees stale-channel energy.

## Interface
- `DATA_W`, 8, debug word width (2..16)
- `NUM_CH`, 4, number of debug channels (1..16)
- `SEL_W`, 2, channel select width; ≥1, must satisfy 2^SEL_W ≥ NUM_CH
- `SETTLE_CYC`, 4, blanking length in cycles (1..255)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  block enable
- `mode`  in  2  00 off, 01 direct LSB, 10 PWM, 11 sigma-delta
- `ch_sel`  in  SEL_W  channel select
- `hold`  in  1  freeze captured sample
- `debug_data`  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- `dbg_ana`  out  1  analog debug bitstream (registered)
- `settling`  out  1  high while in SETTLE
- `sample`  out  DATA_W  currently captured word, for observability

## Operation
- States: OFF, SETTLE, RUN.
- Any state → OFF when `enable`=0 or `mode`=00.
- OFF → SETTLE when `enable`=1 and `mode`≠00.
- RUN → SETTLE when `ch_sel` or `mode` differs from its value registered on the previous cycle. SETTLE also restarts if either changes during SETTLE.
- SETTLE: settle counter counts 0..SETTLE_CYC-1. `dbg_ana`=0 and `settling`=1. PWM counter and sigma-delta accumulator are held at 0. On the last SETTLE cycle `sample` loads the selected channel regardless of `hold`, then the block enters RUN.
- OFF: `dbg_ana`=0, `settling`=0, all counters cleared. `sample` retains its value.
- Channel mux: if `ch_sel` ≥ NUM_CH, the mux yields all zeros.
- RUN, direct mode (01): `sample` reloads every cycle unless `hold`. `dbg_ana` = `sample`[0] (legacy-compatible behaviour).
- RUN, PWM mode (10): `pwm_cnt` is DATA_W bits, free-running from 0 and wrapping at 2^DATA_W-1. `dbg_ana` = (`pwm_cnt` < `sample`). `sample` reloads only on the cycle `pwm_cnt` = 2^DATA_W-1 and `hold`=0, so no period is ever truncated. A sample of 0 gives a constant 0; full scale gives 2^DATA_W-1 highs out of 2^DATA_W cycles.
- RUN, sigma-delta mode (11): `acc` is DATA_W+1 bits. Each cycle `acc` ← {1'b0, `acc`[DATA_W-1:0]} + `sample`, and `dbg_ana` = the new `acc`[DATA_W]. `sample` reloads every cycle unless `hold`. Average density equals `sample`/2^DATA_W exactly over 2^DATA_W cycles.
- `hold`=1 keeps `sample` frozen in RUN. `hold` has no effect on the forced load at the end of SETTLE.

## Timing
- Reset values: state OFF, `dbg_ana`=0, `settling`=0, `sample`=0, all counters 0, registered `ch_sel` and `mode` = 0.
- `dbg_ana` is a flop output. It reflects the state and counters of the same cycle's update, i.e. one clk after the inputs are sampled.
- Enable to first RUN output: `enable` rises at edge N. SETTLE occupies edges N+1..N+SETTLE_CYC. RUN begins at edge N+SETTLE_CYC+1.
- `settling` asserts on the edge SETTLE is entered and deasserts on the edge RUN is entered.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously). No residual PWM period is completed.
- Simultaneous `ch_sel` change and `hold`=1: the change wins; SETTLE reloads `sample`.

## Structure
- Shared package `serdesphy_ana_pkg` holds the mode encodings (`DBG_MODE_OFF`, `DBG_MODE_DIRECT`, `DBG_MODE_PWM`, `DBG_MODE_SDM`) and the state encoding.
- One sub-module is natural: `serdesphy_ana_dbg_modulator`. It contains the PWM counter, the sigma-delta accumulator and the output mux, with inputs `sample`, `mode`, `run` and `clear`.
- The top level contains the channel mux, the change detect, the FSM and the settle counter.

## Test plan
- Defaults, `mode`=11, ch1=8'h40, `enable` rise: `settling` high for 4 cycles, then exactly 64 ones in the next 256 cycles, with the first 1 on the 4th RUN cycle.
- `mode`=10, ch0=8'h80: repeating pattern of 128 highs then 128 lows. Changing ch0 to 8'h20 mid-period takes effect only at the next period start (32 highs).
- `ch_sel` changes 0→2 in RUN, with `hold`=1: `dbg_ana`=0 for 4 cycles, then `sample` equals ch2.
- `mode`=01 with ch0 toggling 8'h01/8'h00 each cycle: `dbg_ana` follows bit 0 one cycle later. Asserting `hold` freezes it.
- `NUM_CH`=3, `ch_sel`=3: `sample`=0 and `dbg_ana` stays 0 in all modes.
- `rst_n` pulsed low during PWM high phase: `dbg_ana`=0 and `sample`=0 immediately, and the block restarts via SETTLE.
